// File: rtl/ofdm_tx_burst_shaper.sv
// Per-burst gain and linear ramp envelope for the OFDM TX sample stream,
// with zero fill, free-running ring write address and stream error counters.
module ofdm_tx_burst_shaper #(
  parameter int ADDRESS_WIDTH = 4,
  parameter int RAMP_LOG2     = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     din_valid,
  input  logic                     din_first,
  input  logic                     din_last,
  input  logic signed [15:0]       din_real,
  input  logic signed [15:0]       din_imag,
  input  logic [15:0]              gain,
  output logic signed [15:0]       dout_real,
  output logic signed [15:0]       dout_imag,
  output logic [ADDRESS_WIDTH-1:0] dout_waddr,
  output logic                     dout_valid,
  output logic                     tx_active,
  output logic [15:0]              underrun_count,
  output logic [15:0]              proto_err_count
);

  localparam int D  = 2 ** RAMP_LOG2;
  localparam int CW = RAMP_LOG2 + 1;
  localparam logic [CW-1:0] F_ONE  = CW'(1);
  localparam logic [CW-1:0] F_FULL = CW'(D);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t                  state_reg;
  logic [15:0]             gain_reg;
  logic [15:0]             underrun_reg;
  logic [15:0]             proto_err_reg;
  logic [ADDRESS_WIDTH-1:0] waddr_reg;

  logic                    in_tag;
  logic                    in_first;
  logic                    in_last;
  logic signed [15:0]      in_data [2];
  logic                    underrun_inc;
  logic                    proto_err_inc;

  // What enters the delay line this cycle: accepted sample, in-burst gap filler, or nothing.
  always_comb begin
    in_tag     = 1'b0;
    in_first   = 1'b0;
    in_last    = 1'b0;
    in_data[0] = '0;
    in_data[1] = '0;
    if (state_reg == IDLE) begin
      if (din_valid && din_first) begin
        in_tag     = 1'b1;
        in_first   = 1'b1;
        in_last    = din_last;
        in_data[0] = din_real;
        in_data[1] = din_imag;
      end
    end else begin
      in_tag = 1'b1;
      if (din_valid) begin
        in_first   = din_first;
        in_last    = din_last;
        in_data[0] = din_real;
        in_data[1] = din_imag;
      end
    end
  end

  assign underrun_inc  = (state_reg == BURST) && !din_valid;
  assign proto_err_inc = din_valid && (((state_reg == IDLE) && !din_first) ||
                                       ((state_reg == BURST) && din_first));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      gain_reg      <= '0;
      underrun_reg  <= '0;
      proto_err_reg <= '0;
      waddr_reg     <= '0;
    end else begin
      waddr_reg <= waddr_reg + ADDRESS_WIDTH'(1);
      if (in_first) gain_reg <= gain;
      case (state_reg)
        IDLE:    if (in_first && !in_last) state_reg <= BURST;
        BURST:   if (din_valid && din_last) state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
      if (underrun_inc && (underrun_reg != 16'hFFFF)) underrun_reg <= underrun_reg + 16'd1;
      if (proto_err_inc && (proto_err_reg != 16'hFFFF)) proto_err_reg <= proto_err_reg + 16'd1;
    end
  end

  // Delay line: D stages so the ramp-down can be scheduled before the tail exits.
  logic signed [15:0] dl_data_reg  [D][2];
  logic               dl_tag_reg   [D];
  logic               dl_first_reg [D];
  logic signed [15:0] feed_data    [D][2];
  logic               feed_tag     [D];
  logic               feed_first   [D];

  genvar gi;
  generate
    for (gi = 0; gi < D; gi++) begin : g_dl
      if (gi == 0) begin : g_head
        assign feed_data[gi][0] = in_data[0];
        assign feed_data[gi][1] = in_data[1];
        assign feed_tag[gi]     = in_tag;
        assign feed_first[gi]   = in_first;
      end else begin : g_link
        assign feed_data[gi][0] = dl_data_reg[gi-1][0];
        assign feed_data[gi][1] = dl_data_reg[gi-1][1];
        assign feed_tag[gi]     = dl_tag_reg[gi-1];
        assign feed_first[gi]   = dl_first_reg[gi-1];
      end
      always_ff @(posedge clk) begin
        if (rst) begin
          dl_data_reg[gi][0] <= '0;
          dl_data_reg[gi][1] <= '0;
          dl_tag_reg[gi]     <= 1'b0;
          dl_first_reg[gi]   <= 1'b0;
        end else begin
          dl_data_reg[gi][0] <= feed_data[gi][0];
          dl_data_reg[gi][1] <= feed_data[gi][1];
          dl_tag_reg[gi]     <= feed_tag[gi];
          dl_first_reg[gi]   <= feed_first[gi];
        end
      end
    end
  endgenerate

  // Envelope factor for the entry leaving the delay line; dn_reg == 0 means no tail pending.
  logic [CW-1:0]    up_reg;
  logic [CW-1:0]    dn_reg;
  logic [CW-1:0]    fu;
  logic [CW-1:0]    fd;
  logic [CW-1:0]    f;
  logic [16+CW-1:0] eff_prod;

  always_comb begin
    fu       = dl_first_reg[D-1] ? F_ONE : ((up_reg >= F_FULL) ? F_FULL : up_reg + F_ONE);
    fd       = (dn_reg == '0) ? F_FULL : dn_reg;
    f        = (fu < fd) ? fu : fd;
    eff_prod = (16+CW)'(gain_reg) * (16+CW)'(f);
  end

  logic [15:0] eff_reg;
  logic        s1_tag_reg;
  logic        s2_tag_reg;
  logic        valid_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      up_reg     <= F_FULL;
      dn_reg     <= '0;
      eff_reg    <= '0;
      s1_tag_reg <= 1'b0;
      s2_tag_reg <= 1'b0;
      valid_reg  <= 1'b0;
    end else begin
      up_reg     <= fu;
      dn_reg     <= in_last ? F_FULL : ((dn_reg != '0) ? dn_reg - F_ONE : '0);
      eff_reg    <= 16'(eff_prod >> RAMP_LOG2);
      s1_tag_reg <= dl_tag_reg[D-1];
      s2_tag_reg <= s1_tag_reg;
      valid_reg  <= s2_tag_reg;
    end
  end

  logic signed [15:0] s1_data_reg [2];
  logic signed [32:0] p_reg       [2];
  logic signed [15:0] out_reg     [2];

  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      logic signed [32:0] rnd;
      logic signed [18:0] shr;
      logic signed [15:0] sat;

      assign rnd = p_reg[gi] + 33'sd8192;
      assign shr = 19'(rnd >>> 14);

      always_comb begin
        if (shr > 19'sd32767)       sat = 16'sh7FFF;
        else if (shr < -19'sd32768) sat = 16'sh8000;
        else                        sat = 16'(shr);
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          s1_data_reg[gi] <= '0;
          p_reg[gi]       <= '0;
          out_reg[gi]     <= '0;
        end else begin
          s1_data_reg[gi] <= dl_data_reg[D-1][gi];
          p_reg[gi]       <= 33'(s1_data_reg[gi]) * 33'($signed({1'b0, eff_reg}));
          out_reg[gi]     <= s2_tag_reg ? sat : 16'sd0;
        end
      end
    end
  endgenerate

  logic dl_any;
  always_comb begin
    dl_any = 1'b0;
    for (int i = 0; i < D; i++) dl_any = dl_any | dl_tag_reg[i];
  end

  assign dout_real       = out_reg[0];
  assign dout_imag       = out_reg[1];
  assign dout_valid      = valid_reg;
  assign dout_waddr      = waddr_reg;
  assign underrun_count  = underrun_reg;
  assign proto_err_count = proto_err_reg;
  assign tx_active       = (state_reg == BURST) | dl_any | s1_tag_reg | s2_tag_reg | valid_reg;

endmodule

// File: tb/tb_ofdm_tx_burst_shaper.sv
// Directed-vector bench for ofdm_tx_burst_shaper (D = 8, 16-entry ring).
module tb_ofdm_tx_burst_shaper;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               din_valid = 1'b0;
  logic               din_first = 1'b0;
  logic               din_last = 1'b0;
  logic signed [15:0] din_real = '0;
  logic signed [15:0] din_imag = '0;
  logic [15:0]        gain = 16'h4000;
  logic signed [15:0] dout_real;
  logic signed [15:0] dout_imag;
  logic [3:0]         dout_waddr;
  logic               dout_valid;
  logic               tx_active;
  logic [15:0]        underrun_count;
  logic [15:0]        proto_err_count;

  ofdm_tx_burst_shaper #(.ADDRESS_WIDTH(4), .RAMP_LOG2(3)) dut (
    .clk(clk), .rst(rst),
    .din_valid(din_valid), .din_first(din_first), .din_last(din_last),
    .din_real(din_real), .din_imag(din_imag), .gain(gain),
    .dout_real(dout_real), .dout_imag(dout_imag), .dout_waddr(dout_waddr),
    .dout_valid(dout_valid), .tx_active(tx_active),
    .underrun_count(underrun_count), .proto_err_count(proto_err_count)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int first_drive_cyc = 0;
  int cap_first_cyc = -1;
  int zero_bad = 0;
  logic signed [15:0] cap_re [$];
  logic signed [15:0] cap_im [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Collects every in-burst output sample; idle cycles must be exact zeros.
  always @(negedge clk) begin
    if (dout_valid === 1'b1) begin
      if (cap_re.size() == 0) cap_first_cyc = cyc;
      cap_re.push_back(dout_real);
      cap_im.push_back(dout_imag);
    end else if (dout_real !== 16'sd0 || dout_imag !== 16'sd0) begin
      zero_bad++;
    end
  end

  task automatic clear_capture();
    cap_re.delete();
    cap_im.delete();
    cap_first_cyc = -1;
    zero_bad = 0;
  endtask

  task automatic drive(input logic v, input logic f, input logic l,
                       input logic signed [15:0] re, input logic signed [15:0] im);
    @(negedge clk);
    din_valid = v; din_first = f; din_last = l; din_real = re; din_imag = im;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 16'sd0, 16'sd0);
  endtask

  task automatic send_burst(input int n, input logic signed [15:0] re, input logic signed [15:0] im);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, i == 0, i == n - 1, re, im);
      if (i == 0) first_drive_cyc = cyc;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    compared += 7;
    if (dout_real !== 16'sd0) begin $display("FAIL reset_real: got %0d want 0", dout_real); mismatched++; end
    if (dout_imag !== 16'sd0) begin $display("FAIL reset_imag: got %0d want 0", dout_imag); mismatched++; end
    if (dout_waddr !== 4'd0) begin $display("FAIL reset_waddr: got %0d want 0", dout_waddr); mismatched++; end
    if (dout_valid !== 1'b0) begin $display("FAIL reset_valid: got %b want 0", dout_valid); mismatched++; end
    if (tx_active !== 1'b0) begin $display("FAIL reset_tx_active: got %b want 0", tx_active); mismatched++; end
    if (underrun_count !== 16'd0) begin $display("FAIL reset_underrun: got %0d want 0", underrun_count); mismatched++; end
    if (proto_err_count !== 16'd0) begin $display("FAIL reset_proto: got %0d want 0", proto_err_count); mismatched++; end
    rst = 1'b0;
    idle(4);
    $display("test_reset: done");
  endtask

  task automatic test_unity();
    gain = 16'h4000;
    clear_capture();
    send_burst(40, 16'sh1234, -16'sh1234);
    compared++;
    if (tx_active !== 1'b1) begin $display("FAIL unity_active_mid: got %b want 1", tx_active); mismatched++; end
    idle(16);
    compared += 6;
    if (tx_active !== 1'b0) begin $display("FAIL unity_active_end: got %b want 0", tx_active); mismatched++; end
    if (cap_re.size() !== 40) begin $display("FAIL unity_valid_len: got %0d want 40", cap_re.size()); mismatched++; end
    if (cap_first_cyc - first_drive_cyc !== 11) begin
      $display("FAIL unity_latency: got %0d want 11", cap_first_cyc - first_drive_cyc); mismatched++;
    end
    if (cap_re[0] !== 16'sh0247) begin $display("FAIL unity_first_re: got %0d want 583", cap_re[0]); mismatched++; end
    if (cap_im[0] !== -16'sh0246) begin $display("FAIL unity_first_im: got %0d want -582", cap_im[0]); mismatched++; end
    if (zero_bad !== 0) begin $display("FAIL unity_zero_fill: got %0d nonzero idle samples want 0", zero_bad); mismatched++; end
    for (int i = 8; i < 32; i++) begin
      compared += 2;
      if (cap_re[i] !== 16'sh1234) begin $display("FAIL unity_re[%0d]: got %0d want 4660", i, cap_re[i]); mismatched++; end
      if (cap_im[i] !== -16'sh1234) begin $display("FAIL unity_im[%0d]: got %0d want -4660", i, cap_im[i]); mismatched++; end
    end
    $display("test_unity: 40-sample burst, %0d outputs", cap_re.size());
  endtask

  task automatic test_ramp();
    int fac;
    logic signed [15:0] exp_v;
    gain = 16'h4000;
    clear_capture();
    send_burst(20, 16'sh4000, 16'sd0);
    idle(16);
    compared++;
    if (cap_re.size() !== 20) begin $display("FAIL ramp_len: got %0d want 20", cap_re.size()); mismatched++; end
    for (int k = 0; k < 20; k++) begin
      fac = (k + 1 < 20 - k) ? k + 1 : 20 - k;
      if (fac > 8) fac = 8;
      exp_v = 16'(fac * 16'h0800);
      compared++;
      if (cap_re[k] !== exp_v) begin $display("FAIL ramp_out[%0d]: got %0h want %0h", k + 1, cap_re[k], exp_v); mismatched++; end
    end
    $display("test_ramp: 20-sample burst, %0d outputs", cap_re.size());
  endtask

  task automatic test_short();
    gain = 16'h4000;
    clear_capture();
    send_burst(3, 16'sh4000, 16'sh4000);
    idle(16);
    compared += 4;
    if (cap_re.size() !== 3) begin $display("FAIL short_len: got %0d want 3", cap_re.size()); mismatched++; end
    if (cap_re[0] !== 16'sh0800) begin $display("FAIL short_0: got %0h want 800", cap_re[0]); mismatched++; end
    if (cap_re[1] !== 16'sh1000) begin $display("FAIL short_1: got %0h want 1000", cap_re[1]); mismatched++; end
    if (cap_im[2] !== 16'sh0800) begin $display("FAIL short_2: got %0h want 800", cap_im[2]); mismatched++; end
    clear_capture();
    send_burst(1, 16'sh4000, 16'sh4000);
    idle(16);
    compared += 2;
    if (cap_re.size() !== 1) begin $display("FAIL single_len: got %0d want 1", cap_re.size()); mismatched++; end
    if (cap_re[0] !== 16'sh0800) begin $display("FAIL single_val: got %0h want 800", cap_re[0]); mismatched++; end
    $display("test_short: 3-sample and 1-sample bursts");
  endtask

  task automatic test_saturation();
    logic signed [15:0] re;
    logic signed [15:0] im;
    gain = 16'hFFFF;
    clear_capture();
    for (int i = 0; i < 20; i++) begin
      re = 16'sd0; im = 16'sd0;
      if (i == 8)  begin re = 16'sh7FFF; im = 16'sh8000; end
      if (i == 9)  begin re = 16'sh8000; im = 16'sh7FFF; end
      if (i == 10) begin re = 16'sh1000; im = -16'sh1000; end
      drive(1'b1, i == 0, i == 19, re, im);
    end
    idle(16);
    compared += 6;
    if (cap_re[8] !== 16'sh7FFF) begin $display("FAIL sat_pos_re: got %0d want 32767", cap_re[8]); mismatched++; end
    if (cap_im[8] !== 16'sh8000) begin $display("FAIL sat_neg_im: got %0d want -32768", cap_im[8]); mismatched++; end
    if (cap_re[9] !== 16'sh8000) begin $display("FAIL sat_neg_re: got %0d want -32768", cap_re[9]); mismatched++; end
    if (cap_im[9] !== 16'sh7FFF) begin $display("FAIL sat_pos_im: got %0d want 32767", cap_im[9]); mismatched++; end
    if (cap_re[10] !== 16'sh4000) begin $display("FAIL sat_round_re: got %0h want 4000", cap_re[10]); mismatched++; end
    if (cap_im[10] !== -16'sh4000) begin $display("FAIL sat_round_im: got %0d want -16384", cap_im[10]); mismatched++; end
    $display("test_saturation: gain ffff burst");
  endtask

  task automatic test_underrun();
    gain = 16'h4000;
    clear_capture();
    for (int i = 0; i < 10; i++) drive(1'b1, i == 0, 1'b0, 16'sh4000, 16'sd0);
    drive(1'b0, 1'b0, 1'b0, 16'sd0, 16'sd0);
    drive(1'b0, 1'b0, 1'b0, 16'sd0, 16'sd0);
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, i == 9, 16'sh4000, 16'sd0);
    idle(16);
    compared += 7;
    if (underrun_count !== 16'd2) begin $display("FAIL underrun_count: got %0d want 2", underrun_count); mismatched++; end
    if (cap_re.size() !== 22) begin $display("FAIL underrun_len: got %0d want 22", cap_re.size()); mismatched++; end
    if (cap_re[9] !== 16'sh4000) begin $display("FAIL underrun_before: got %0h want 4000", cap_re[9]); mismatched++; end
    if (cap_re[10] !== 16'sd0) begin $display("FAIL underrun_gap0: got %0h want 0", cap_re[10]); mismatched++; end
    if (cap_re[11] !== 16'sd0) begin $display("FAIL underrun_gap1: got %0h want 0", cap_re[11]); mismatched++; end
    if (cap_re[12] !== 16'sh4000) begin $display("FAIL underrun_after: got %0h want 4000", cap_re[12]); mismatched++; end
    if (cap_re[21] !== 16'sh0800) begin $display("FAIL underrun_tail: got %0h want 800", cap_re[21]); mismatched++; end
    $display("test_underrun: 2-cycle gap, count %0d", underrun_count);
  endtask

  task automatic test_proto_idle();
    clear_capture();
    drive(1'b1, 1'b0, 1'b0, 16'sh4000, 16'sh4000);
    idle(16);
    compared += 3;
    if (proto_err_count !== 16'd1) begin $display("FAIL proto_idle_count: got %0d want 1", proto_err_count); mismatched++; end
    if (cap_re.size() !== 0) begin $display("FAIL proto_idle_output: got %0d samples want 0", cap_re.size()); mismatched++; end
    if (tx_active !== 1'b0) begin $display("FAIL proto_idle_active: got %b want 0", tx_active); mismatched++; end
    $display("test_proto_idle: stray sample dropped");
  endtask

  task automatic test_restart();
    int fac [24] = '{1, 2, 3, 4, 5, 6, 7, 8, 8, 8, 8, 8,
                     1, 2, 3, 4, 5, 6, 6, 5, 4, 3, 2, 1};
    logic signed [15:0] exp_v;
    gain = 16'h4000;
    clear_capture();
    for (int i = 0; i < 12; i++) drive(1'b1, i == 0, 1'b0, 16'sh4000, 16'sd0);
    for (int i = 0; i < 12; i++) drive(1'b1, i == 0, i == 11, 16'sh4000, 16'sd0);
    idle(16);
    compared += 2;
    if (proto_err_count !== 16'd2) begin $display("FAIL restart_proto: got %0d want 2", proto_err_count); mismatched++; end
    if (cap_re.size() !== 24) begin $display("FAIL restart_len: got %0d want 24", cap_re.size()); mismatched++; end
    for (int k = 0; k < 24; k++) begin
      exp_v = 16'(fac[k] * 16'h0800);
      compared++;
      if (cap_re[k] !== exp_v) begin $display("FAIL restart_out[%0d]: got %0h want %0h", k, cap_re[k], exp_v); mismatched++; end
    end
    $display("test_restart: first mid-burst");
  endtask

  task automatic test_reset_mid_burst();
    gain = 16'h4000;
    clear_capture();
    for (int i = 0; i < 15; i++) drive(1'b1, i == 0, 1'b0, 16'sh4000, 16'sh4000);
    compared++;
    if (dout_valid !== 1'b1) begin $display("FAIL rstmid_pre_valid: got %b want 1", dout_valid); mismatched++; end
    @(negedge clk);
    rst = 1'b1; din_valid = 1'b0; din_first = 1'b0; din_last = 1'b0;
    @(negedge clk);
    compared += 7;
    if (dout_real !== 16'sd0) begin $display("FAIL rstmid_real: got %0d want 0", dout_real); mismatched++; end
    if (dout_imag !== 16'sd0) begin $display("FAIL rstmid_imag: got %0d want 0", dout_imag); mismatched++; end
    if (dout_valid !== 1'b0) begin $display("FAIL rstmid_valid: got %b want 0", dout_valid); mismatched++; end
    if (dout_waddr !== 4'd0) begin $display("FAIL rstmid_waddr: got %0d want 0", dout_waddr); mismatched++; end
    if (tx_active !== 1'b0) begin $display("FAIL rstmid_active: got %b want 0", tx_active); mismatched++; end
    if (underrun_count !== 16'd0) begin $display("FAIL rstmid_underrun: got %0d want 0", underrun_count); mismatched++; end
    if (proto_err_count !== 16'd0) begin $display("FAIL rstmid_proto: got %0d want 0", proto_err_count); mismatched++; end
    rst = 1'b0;
    clear_capture();
    idle(16);
    compared += 2;
    if (cap_re.size() !== 0) begin $display("FAIL rstmid_flush: got %0d samples want 0", cap_re.size()); mismatched++; end
    if (tx_active !== 1'b0) begin $display("FAIL rstmid_active_after: got %b want 0", tx_active); mismatched++; end
    $display("test_reset_mid_burst: pipeline flushed");
  endtask

  task automatic test_waddr();
    logic [3:0] exp_a;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    compared++;
    if (dout_waddr !== 4'd0) begin $display("FAIL waddr_reset: got %0d want 0", dout_waddr); mismatched++; end
    rst = 1'b0;
    for (int i = 1; i < 36; i++) begin
      if (i <= 6) drive(1'b1, i == 1, i == 6, 16'sh4000, 16'sd0);
      else        drive(1'b0, 1'b0, 1'b0, 16'sd0, 16'sd0);
      exp_a = 4'(i);
      compared++;
      if (dout_waddr !== exp_a) begin $display("FAIL waddr[%0d]: got %0d want %0d", i, dout_waddr, exp_a); mismatched++; end
    end
    $display("test_waddr: 35 cycles through burst and idle");
  endtask

  initial begin
    test_reset();
    test_unity();
    test_ramp();
    test_short();
    test_saturation();
    test_underrun();
    test_proto_idle();
    test_restart();
    test_reset_mid_burst();
    test_waddr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
